// File: rtl/vec_mac_array.sv
// rtl/vec_mac_array.sv - pipelined signed fixed-point vector multiplier with elementwise and dot-product modes
`timescale 1ns/1ps
module vec_mac_array #(
  parameter int LANES = 4,
  parameter int W     = 16,
  parameter int FRAC  = 8,
  parameter int ACC_W = 48
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic                 in_last,
  input  logic [LANES*W-1:0]   in_a,
  input  logic [LANES*W-1:0]   in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   out_y,
  output logic                 out_ovf
);

  localparam int PW = 2 * W;
  localparam logic signed [PW:0]      HALF_E = {{PW{1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] HALF_D = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic [W-1:0]            MAX_W  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]            MIN_W  = {1'b1, {(W-1){1'b0}}};

  logic adv;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  logic                   s1_valid;
  logic                   s1_mode;
  logic                   s1_last;
  logic signed [PW-1:0]   s1_p [LANES];
  logic signed [PW-1:0]   prod [LANES];
  logic signed [ACC_W-1:0] acc;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod[i] = PW'($signed(in_a[(LANES-1-i)*W +: W])) * PW'($signed(in_b[(LANES-1-i)*W +: W]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_last  <= 1'b0;
      for (int i = 0; i < LANES; i++) s1_p[i] <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode <= in_mode;
        s1_last <= in_last;
        for (int i = 0; i < LANES; i++) s1_p[i] <= prod[i];
      end
    end
  end

  // Rounded value fits W bits iff its bits [top:W-1] are all equal.
  logic signed [PW:0]      ew_r;
  logic [W-1:0]            ew_lane;
  logic [LANES*W-1:0]      ew_y;
  logic                    ew_ovf;
  logic signed [ACC_W-1:0] dot_s;
  logic signed [ACC_W-1:0] dot_t;
  logic signed [ACC_W-1:0] dot_r;
  logic [W-1:0]            dot_lane;
  logic [LANES*W-1:0]      dot_y;
  logic                    dot_ovf;

  always_comb begin
    ew_r    = '0;
    ew_lane = '0;
    ew_y    = '0;
    ew_ovf  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      ew_r = ($signed({s1_p[i][PW-1], s1_p[i]}) + HALF_E) >>> FRAC;
      if ((&ew_r[PW:W-1]) || !(|ew_r[PW:W-1])) begin
        ew_lane = ew_r[W-1:0];
      end else begin
        ew_lane = ew_r[PW] ? MIN_W : MAX_W;
        ew_ovf  = 1'b1;
      end
      ew_y[(LANES-1-i)*W +: W] = ew_lane;
    end

    dot_s = '0;
    for (int i = 0; i < LANES; i++) begin
      dot_s = dot_s + ACC_W'(s1_p[i]);
    end
    dot_t = acc + dot_s;
    dot_r = (dot_t + HALF_D) >>> FRAC;
    if ((&dot_r[ACC_W-1:W-1]) || !(|dot_r[ACC_W-1:W-1])) begin
      dot_lane = dot_r[W-1:0];
      dot_ovf  = 1'b0;
    end else begin
      dot_lane = dot_r[ACC_W-1] ? MIN_W : MAX_W;
      dot_ovf  = 1'b1;
    end
    dot_y = '0;
    dot_y[LANES*W-1 -: W] = dot_lane;
  end

  // Elementwise beats bypass acc so an interleaved dot vector resumes intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_ovf   <= 1'b0;
      acc       <= '0;
    end else if (adv) begin
      if (s1_valid && !s1_mode) begin
        out_valid <= 1'b1;
        out_y     <= ew_y;
        out_ovf   <= ew_ovf;
      end else if (s1_valid && s1_last) begin
        out_valid <= 1'b1;
        out_y     <= dot_y;
        out_ovf   <= dot_ovf;
        acc       <= '0;
      end else begin
        out_valid <= 1'b0;
        if (s1_valid) acc <= dot_t;
      end
    end
  end

endmodule

// File: tb/tb_vec_mac_array.sv
// tb/tb_vec_mac_array.sv - directed self-checking bench for vec_mac_array
`timescale 1ns/1ps
module tb_vec_mac_array;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic        in_last;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_y;
  logic        out_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  vec_mac_array #(.LANES(4), .W(16), .FRAC(8), .ACC_W(48)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_last(in_last),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pk(input logic [15:0] l0, l1, l2, l3);
    return {l0, l1, l2, l3};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one beat from a negedge; returns just after the accepting edge.
  task automatic beat(input logic mode, input logic last, input logic [63:0] a, input logic [63:0] b);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = mode;
    in_last  = last;
    in_a     = a;
    in_b     = b;
    n = 0;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [63:0] y, input logic ovf);
    chk({tag, "_lat"}, 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_y"}, out_y, y);
    chk({tag, "_ovf"}, 64'(out_ovf), 64'(ovf));
  endtask

  task automatic expect_none(input string tag);
    @(posedge clk);
    #1;
    chk(tag, 64'(out_valid), 64'd0);
  endtask

  logic [63:0] bp_a [8];
  logic [63:0] one_x4;
  logic [63:0] held;
  logic        stalled;
  int          sent;
  int          recv;
  int          cyc;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_last   = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    one_x4    = pk(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    #22;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_y", out_y, 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Elementwise Q8.8 with one saturating lane
    beat(1'b0, 1'b0, pk(16'h0180, 16'hFF00, 16'h0001, 16'h7FFF),
                     pk(16'h0200, 16'h0200, 16'h0080, 16'h7FFF));
    expect_out("ew", pk(16'h0300, 16'hFE00, 16'h0001, 16'h7FFF), 1'b1);
    expect_none("ew_drain");

    // Two-beat dot vector, then a single-beat vector proves acc was cleared
    beat(1'b1, 1'b0, one_x4, pk(16'h0200, 16'h0200, 16'h0200, 16'h0200));
    beat(1'b1, 1'b1, one_x4, pk(16'h0200, 16'h0200, 16'h0200, 16'h0200));
    expect_out("dot2", pk(16'h1000, 16'h0000, 16'h0000, 16'h0000), 1'b0);
    expect_none("dot2_single");
    beat(1'b1, 1'b1, one_x4, one_x4);
    expect_out("dot1", pk(16'h0400, 16'h0000, 16'h0000, 16'h0000), 1'b0);
    expect_none("dot1_drain");

    // Dot saturation and negative rounding toward +inf
    beat(1'b1, 1'b1, pk(16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00),
                     pk(16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00));
    expect_out("dot_sat", pk(16'h7FFF, 16'h0000, 16'h0000, 16'h0000), 1'b1);
    expect_none("dot_sat_drain");
    beat(1'b1, 1'b1, pk(16'hFFFF, 16'h0000, 16'h0000, 16'h0000),
                     pk(16'h0080, 16'h0000, 16'h0000, 16'h0000));
    expect_out("dot_neg", 64'd0, 1'b0);
    expect_none("dot_neg_drain");

    // Elementwise beat interleaved inside a dot vector
    beat(1'b1, 1'b0, one_x4, pk(16'h0200, 16'h0200, 16'h0200, 16'h0200));
    expect_none("il_dot_first");
    beat(1'b0, 1'b0, pk(16'h0100, 16'h0000, 16'h0000, 16'h0000),
                     pk(16'h0300, 16'h0000, 16'h0000, 16'h0000));
    expect_out("il_ew", pk(16'h0300, 16'h0000, 16'h0000, 16'h0000), 1'b0);
    beat(1'b1, 1'b1, one_x4, one_x4);
    expect_out("il_dot", pk(16'h0C00, 16'h0000, 16'h0000, 16'h0000), 1'b0);
    expect_none("il_drain");

    // Backpressure: out_ready pattern 1,0,0,1 with 8 elementwise beats (b = 1.0 so y = a)
    for (int k = 0; k < 8; k++) begin
      bp_a[k] = pk(16'((k*4+1)*256), 16'((k*4+2)*256), 16'((k*4+3)*256), 16'((k*4+4)*256));
    end
    sent    = 0;
    recv    = 0;
    cyc     = 0;
    stalled = 1'b0;
    held    = '0;
    while (recv < 8 && cyc < 80) begin
      @(negedge clk);
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid  = (sent < 8);
      in_mode   = 1'b0;
      in_last   = 1'b0;
      in_a      = bp_a[(sent < 8) ? sent : 0];
      in_b      = one_x4;
      #1;
      chk("bp_in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (stalled) begin
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_y", out_y, held);
      end
      if (out_valid && out_ready) begin
        chk("bp_y", out_y, bp_a[recv]);
        recv++;
      end
      stalled = out_valid && !out_ready;
      held    = out_y;
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    chk("bp_count", 64'(recv), 64'd8);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    expect_none("bp_drain");

    // Reset mid-vector while an output is stalled
    beat(1'b1, 1'b0, one_x4, pk(16'h0200, 16'h0200, 16'h0200, 16'h0200));
    out_ready = 1'b0;
    beat(1'b0, 1'b0, one_x4, one_x4);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_y", out_y, 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    beat(1'b1, 1'b1, one_x4, one_x4);
    expect_out("post_rst", pk(16'h0400, 16'h0000, 16'h0000, 16'h0000), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
